// File: rtl/imem_loader_pkg.sv
// Shared definitions for the IMEM loader: FSM states and image geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE
  } state_e;

  localparam int IMEM_DEPTH = 1024;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes big-endian into a 32-bit word and flags the 4th byte.
// Latency: word_dat/word_full are combinational in the cycle the 4th byte is presented.
// Backpressure: none; only counts bytes the parent has already accepted.
// Ports: byte_vld/byte_dat = accepted byte, clr = restart byte count,
//        word_dat = {first three bytes, current byte}, word_full = current byte completes a word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word_dat,
  output logic        word_full
);

  logic [1:0]  cnt_q,   cnt_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_full = byte_vld && (cnt_q == 2'(WORD_BYTES - 1));
    // Earlier bytes sit above the incoming one, so the first byte ends up in 31:24.
    word_dat  = {shift_q, byte_dat};
    if (clr) begin
      cnt_d = 2'd0;
    end else if (byte_vld) begin
      shift_d = {shift_q[15:0], byte_dat};
      cnt_d   = cnt_q + 2'd1;  // wraps to 0 after the 4th byte
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into IMEM as word-aligned 32-bit writes, holding the CPU until done.
// Latency: word written the cycle after its 4th byte is accepted; 5 cycles per word at full rate.
// Backpressure: in_ready low outside header/data states and during the WRITE cycle; producer holds the byte.
// Ports: start, in_valid/in_data/in_ready byte stream; wr_en/wr_addr/wr_data IMEM write port;
//        words_loaded, done, err (sticky overflow), cpu_hold status.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [CNT_W-1:0] words_loaded,
  output logic             done,
  output logic             err,
  output logic             cpu_hold
);

  state_e             state_q, state_d;
  logic [7:0]         hdr_hi_q, hdr_hi_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic [CNT_W-1:0]   words_loaded_q, words_loaded_d;
  logic               err_q, err_d;

  logic               accept;
  logic               start_ok;
  logic               in_range;
  logic [CNT_W-1:0]   hdr_n;
  logic [31:0]        pk_word;
  logic               pk_full;

  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign in_range = (32'(idx_q) < 32'(DEPTH));
  assign hdr_n    = CNT_W'({hdr_hi_q, in_data});

  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_ok),
    .byte_vld  (accept && (state_q == DATA)),
    .byte_dat  (in_data),
    .word_dat  (pk_word),
    .word_full (pk_full)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = HDR_HI;
      HDR_HI:     if (accept) state_d = HDR_LO;
      HDR_LO:     if (accept) state_d = (hdr_n == '0) ? DONE : DATA;
      DATA:       if (pk_full) state_d = WRITE;
      WRITE:      state_d = ((idx_q + 1'b1) == n_q) ? DONE : DATA;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
    wr_en    = (state_q == WRITE) && in_range;
    done     = (state_q == DONE);
    cpu_hold = (state_q != DONE);
  end

  // Header, word index, write port and status registers
  always_comb begin
    hdr_hi_d       = hdr_hi_q;
    n_d            = n_q;
    idx_d          = idx_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    words_loaded_d = words_loaded_q;
    err_d          = err_q;

    if (start_ok) begin
      words_loaded_d = '0;
      err_d          = 1'b0;
    end
    if ((state_q == HDR_HI) && accept) hdr_hi_d = in_data;
    if ((state_q == HDR_LO) && accept) begin
      n_d   = hdr_n;
      idx_d = '0;
    end
    // Capture on the 4th byte so the write port is stable throughout WRITE;
    // out-of-range words leave the port holding the last real write.
    if (pk_full && in_range) begin
      wr_addr_d = 32'(idx_q) << 2;
      wr_data_d = pk_word;
    end
    if (state_q == WRITE) begin
      idx_d = idx_q + 1'b1;
      if (in_range) words_loaded_d = words_loaded_q + 1'b1;
      else          err_d          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_hi_q       <= 8'd0;
      n_q            <= '0;
      idx_q          <= '0;
      wr_addr_q      <= 32'd0;
      wr_data_q      <= 32'd0;
      words_loaded_q <= '0;
      err_q          <= 1'b0;
    end else begin
      hdr_hi_q       <= hdr_hi_d;
      n_q            <= n_d;
      idx_q          <= idx_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      words_loaded_q <= words_loaded_d;
      err_q          <= err_d;
    end
  end

  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign words_loaded = words_loaded_q;
  assign err          = err_q;

endmodule
